// File: rtl/reg_bank_if.sv
// Write/clear request bus and flat read view between the register bank and its user.
interface reg_bank_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
);
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [WIDTH/8-1:0]       wr_be;
  logic                     wr_ack;
  logic                     wr_err;
  logic                     init_req;
  logic                     busy;
  logic                     init_done;
  logic [DEPTH*WIDTH-1:0]   rd_bus;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, init_req,
    input  wr_ack, wr_err, busy, init_done, rd_bus
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, init_req,
    output wr_ack, wr_err, busy, init_done, rd_bus
  );
endinterface

// File: rtl/reg_bank_32x32.sv
// 32x32 register bank feeding the read mux: byte-masked writes with ack/err,
// sequenced one-word-per-cycle bulk clear, all words exposed on a flat bus.
module reg_bank_32x32 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_bank_if.slave   bus
);

  localparam int unsigned NB = WIDTH / 8;
  localparam bit          ZR = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            clr_en;
  logic            busy_d;
  logic            done_d;
  logic            wr_blocked;
  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_blocked = ZR && (bus.wr_addr == '0);

  // Next-state, sweep counter and write-acceptance decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          accept = bus.wr_en;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
    done_d = (state_d == DONE);
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus.busy      <= 1'b0;
      bus.init_done <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.wr_err    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus.busy      <= busy_d;
      bus.init_done <= done_d;
      bus.wr_ack    <= accept;
      bus.wr_err    <= bus.wr_en && !accept;
    end
  end

  // Storage: the sweep owns the bank while clearing, otherwise byte-masked writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (clr_en) begin
      mem[cnt_q] <= '0;
    end else if (accept && !wr_blocked) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_rd
    assign bus.rd_bus[k*WIDTH +: WIDTH] = mem[k];
  end

endmodule
